// File: rtl/alu_fn_pkg.sv
// Shared definitions for the lab ALU accumulator: function codes and FSM state encoding.
package alu_fn_pkg;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_CAT = 3'b011;
  localparam logic [2:0] FN_MUL = 3'b100;
  localparam logic [2:0] FN_SHL = 3'b101;
  localparam logic [2:0] FN_SHR = 3'b110;
  localparam logic [2:0] FN_CLR = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/ripple_add4.sv
// 4-bit ripple-carry adder assembled from full-adder cells.
module ripple_add4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign sum_o[g]     = a_i[g] ^ b_i[g] ^ carry[g];
    assign carry[g + 1] = (a_i[g] & b_i[g]) | (carry[g] & (a_i[g] ^ b_i[g]));
  end

  assign cout_o = carry[4];

endmodule

// File: rtl/alu_accum.sv
// Registered accumulator stage: combines operand A with R[3:0] on Go; multiply is 4-cycle shift-add.
module alu_accum
  import alu_fn_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] A,
  input  logic [2:0] Func,
  input  logic       Go,
  output logic [7:0] R,
  output logic       Busy,
  output logic       Done
);

  state_e     state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [7:0] p_q, p_d;
  logic [1:0] i_q, i_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] add_sum;
  logic       add_cout;
  logic [7:0] addend;
  logic [7:0] p_next;

  ripple_add4 u_add (
    .a_i    (A),
    .b_i    (r_q[3:0]),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign addend = q_q[i_q] ? ({4'b0000, m_q} << i_q) : 8'h00;
  assign p_next = p_q + addend;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    i_d     = i_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Go) begin
          if (Func == FN_MUL) begin
            state_d = ST_MUL;
            m_d     = A;
            q_d     = r_q[3:0];
            p_d     = 8'h00;
            i_d     = 2'd0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
            unique case (Func)
              FN_ADD:  r_d = {3'b000, add_cout, add_sum};
              FN_OR:   r_d = {7'b0, |{A, r_q[3:0]}};
              FN_AND:  r_d = {7'b0, &{A, r_q[3:0]}};
              FN_CAT:  r_d = {A, r_q[3:0]};
              FN_SHL:  r_d = r_q << A[2:0];
              FN_SHR:  r_d = r_q >> A[2:0];
              FN_CLR:  r_d = 8'h00;
              default: r_d = r_q;
            endcase
          end
        end
      end
      ST_MUL: begin
        p_d = p_next;
        i_d = i_q + 2'd1;
        // Last iteration writes the full product directly so R never sees a partial value.
        if (i_q == 2'd3) begin
          r_d     = p_next;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      r_q     <= 8'h00;
      m_q     <= 4'h0;
      q_q     <= 4'h0;
      p_q     <= 8'h00;
      i_q     <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign R    = r_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: doc/alu_accum.md
# alu_accum

Registered accumulator stage for the 4-bit lab ALU datapath. It takes a 4-bit operand and a function code, and combines the operand with the low nibble of its own 8-bit result register. Results are written back on a Go handshake, and multiply is a multi-cycle shift-add. R drives the board's HEX decoders and is the value fed back to the ALU as operand B.

## Interface
- No parameters; widths are fixed at a 4-bit operand and an 8-bit result.

Ports:
- Clock  in  1  sole clock; rising edge.
- Resetn  in  1  reset; asynchronous, active-low.
- A  in  4  operand A, sampled on the edge that accepts Go.
- Func  in  3  function code, sampled with A.
- Go  in  1  request strobe; level-sampled on each rising edge.
- R  out  8  result register; operand B is R[3:0].
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse in the cycle after R is written.

## Operation
- B = R[3:0], taken at accept time.
- Go is accepted only in IDLE. Go in MUL is ignored; it is not queued.

Function codes:
- 000 ADD: R <= {3'b0, cout, sum} of A + B, carry-in 0.
- 001 OR: R <= {7'b0, |{A,B}}.
- 010 AND: R <= {7'b0, &{A,B}}.
- 011 CAT: R <= {A,B}.
- 100 MUL: R <= A*B, unsigned. The product never exceeds 8'hE1, so there is no overflow.
- 101 SHL: R <= R << A[2:0], zero-fill.
- 110 SHR: R <= R >> A[2:0], zero-fill.
- 111 CLR: R <= 8'h00.

Multiply:
- On accept, capture M = A, Q = B, P = 0, i = 0.
- Each MUL cycle: if Q[i], P <= P + (M << i); then i <= i+1.
- After the iteration with i = 3, write P to R and return to IDLE.

State machine:
- IDLE: Go with Func = 100 -> MUL; any other Go does a single-cycle update and stays in IDLE.
- MUL: 4 iterations, then -> IDLE.

## Timing
- Reset values: R = 8'h00, Busy = 0, Done = 0, state IDLE, internal M/Q/P/i cleared.
- Single-cycle ops: Go accepted at edge k; R is updated at edge k; Done is high from edge k until edge k+1.
- MUL: Go accepted at edge k; Busy is high from edge k.
  - Iterations run on edges k+1 to k+4.
  - R is written and Busy drops at edge k+4; Done is high from edge k+4 until edge k+5.
  - R holds its old value until edge k+4.
- Back-to-back: in IDLE, Go held high issues one operation per edge. A new Go at edge k+4 is not accepted; the earliest new accept after a MUL is edge k+5.
- Resetn low at any time, including mid-multiply, forces all reset values immediately. A partial product is discarded and R is never left partially written.
- A and Func are don't-care outside the accept edge; changing them during MUL has no effect.

## Structure
- Shared package alu_fn_pkg holds:
  - the 3-bit function-code constants (FN_ADD through FN_CLR);
  - the state encoding (ST_IDLE, ST_MUL).
- Sub-module ripple_add4: a 4-bit ripple-carry adder built from full-adder cells, used for ADD.
- MUL accumulation uses a plain 8-bit add.

## Test plan
- Reset: assert Resetn low mid-cycle -> R = 00, Busy = 0, Done = 0 with no clock edge required.
- ADD chain: from R = 00, Go ADD A = 5 -> R = 05, Done for 1 cycle. Then Go ADD A = F -> R = 14 (carry out in bit 4).
- Logic and CAT with R = 14 (B = 4):
  - Go CAT A = A -> R = A4;
  - then Go OR A = 0 -> R = 01;
  - then Go AND A = F -> R = 00.
- MUL: CLR, then ADD F (R = 0F), then Go MUL A = F.
  - Busy is high for 4 cycles and R stays 0F.
  - At edge k+4, R = E1; Done pulses once.
  - Go asserted during MUL is ignored.
- Shifts: with R = E1, Go SHR A = 4 -> R = 0E; then Go SHL A = 7 -> R = 00.
- Abort: start MUL (A = 3, B = 3) and pull Resetn low after 2 cycles -> R = 00, Busy = 0, no Done. A subsequent operation behaves as from a fresh reset.
